viterbi_acs_array: RTL
======================

Name: viterbi_acs_array

Overview:
Parametrised add-compare-select array for the convolutional Viterbi decoder. It is the successor of the fixed two-butterfly ACS.
- Processes all 2^(K-1) trellis states in parallel, one symbol per cycle.
- Derives branch labels from generator polynomials.
- Applies threshold normalisation internally and supports known-state and uniform starts.
- Reports the best state one cycle after the decisions.
- Sits between the branch-metric unit (upstream) and survivor memory / traceback (downstream).

Parameters:
- K, 3: constraint length; NUM_STATES = 2^(K-1), K in 3..9.
- G0, 3'o7: generator polynomial for output bit 0, K bits.
- G1, 3'o5: generator polynomial for output bit 1, K bits.
- METRIC_W, 14: path-metric width, unsigned.
- BM_W, 6: branch-metric width, unsigned.
- NORM_THRESH, 4096: normalisation threshold; must be at most 2^(METRIC_W-2).
- INIT_BIAS, 512: initial metric of non-zero states on a known-state start.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- start  in  1  pulse: begin a new frame from state 0.
- start_uniform  in  1  pulse: begin a new frame with all states equal.
- in_valid  in  1  branch metrics valid for one symbol.
- bm  in  4*BM_W  branch metrics; slice c holds the metric for codeword c = {c1,c0}.
- dec_valid  out  1  dec_bits valid.
- dec_bits  out  NUM_STATES  survivor decision per new state.
- norm_event  out  1  normalisation applied to this symbol (aligned with dec_valid).
- best_valid  out  1  best_state / best_metric valid.
- best_state  out  K-1  index of the minimum path metric.
- best_metric  out  METRIC_W  minimum path metric.
- sym_cnt  out  16  symbols accepted since the last start, saturating.

Behaviour:
- Reset (rst=0, async): all pm = 0; all outputs 0; sym_cnt = 0.
- Trellis, for new state j:
  - u = j[0].
  - Predecessors p0 = j>>1 and p1 = (j>>1) | 2^(K-2).
  - Encoder register r = {p, u}, K bits, u in the LSB.
  - ci = XOR-reduce(r & Gi); codeword c = {c1,c0}.
- Per accepted symbol (in_valid=1), every state is computed in parallel within one cycle:
  - Base metric b[p] = pm[p] - (norm ? NORM_THRESH : 0).
  - norm = (min over current pm >= NORM_THRESH).
  - cand0 = b[p0] + bm[c(p0,u)]; cand1 = b[p1] + bm[c(p1,u)].
  - dec_bits[j] = (cand1 < cand0); ties select 0.
  - pm[j] <= selected candidate.
- Latency: dec_bits, dec_valid and norm_event are registered one cycle after the in_valid cycle.
  - dec_valid is a single-cycle pulse per symbol.
  - dec_bits holds its value until the next symbol.
- Best-state stage:
  - One cycle after dec_valid: best_valid pulses and best_state / best_metric register the minimum of the updated pm.
  - Ties resolve to the lowest index.
- No overflow by construction: min stays below NORM_THRESH + 2^BM_W after normalisation and spread is bounded by (K-1)*(2^BM_W - 1). Overflow checking is an assertion only; no saturation logic.
- start: pm[0] = 0 and all other states = INIT_BIAS; sym_cnt = 0.
- start_uniform: all pm = 0; sym_cnt = 0.
- Both start and start_uniform asserted: start_uniform wins.
- Start and in_valid in the same cycle: the symbol is processed on the initialised metrics (it becomes the first symbol of the frame); sym_cnt = 1.
- Start with in_valid=0: pipeline valids already in flight still complete.
- sym_cnt increments on each accepted symbol and saturates at 65535.
- in_valid gaps: pm hold; no dec_valid or best_valid pulses; back-to-back symbols are accepted every cycle.
- Async reset mid-frame: all state is cleared immediately; no output pulses while rst=0 or in the cycle rst is released.

Decomposition:
- Package viterbi_pkg holds:
  - NUM_STATES derivation.
  - A codeword-lookup function (state, u, G0, G1) returning 2 bits.
  - The metric typedef, width METRIC_W.
  - The bm slice-extract function.
- One sub-module, viterbi_acs_butterfly: handles a pair of new states (2i, 2i+1) sharing predecessors (i, i+2^(K-2)); instantiated NUM_STATES/2 times via generate.
- The min-tree lives in the top level.

Test Plan:
- Known start: start with in_valid, bm = {00:0, 01:4, 10:4, 11:8}, K=3 defaults → dec_bits[0]=0, pm[0]=0; next cycle best_valid=1, best_state=0, best_metric=0, sym_cnt=1.
- All-zero stream: start, then 20 symbols with bm = {0,10,10,10} → best_state stays 0 with best_metric 0; dec_bits[0]=0 on every symbol; norm_event never asserts.
- Normalisation: start_uniform, then 67 symbols with all bm = 63.
  - Symbols 1-66: norm_event=0 and best_metric = 63n (4158 at n=66).
  - Symbol 67: norm_event=1 and best_metric = 125.
  - All dec_bits = 0 (ties); best_state = 0.
- Priority and gaps: start and start_uniform together with in_valid, bm all 5 → all pm = 5, sym_cnt = 1. Then 3 idle cycles → no dec_valid, pm unchanged.
- Reset mid-frame: drop rst for 1 cycle during back-to-back symbols → outputs 0 immediately; no pulse in the release cycle; next symbol processed from pm = 0.
- Random regression: K=5 (G0=5'o23, G1=5'o35) encode a random 1000-bit stream, apply hard-decision bm with 3% bit errors → reference-model match of dec_bits and best_metric every symbol.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi ACS array: state count, trellis
// codeword lookup and branch-metric bus slicing.
package viterbi_pkg;

    localparam int METRIC_W_DEF = 14;
    localparam int BM_W_MAX     = 16;
    localparam int BUS_W        = 4 * BM_W_MAX;

    typedef logic [METRIC_W_DEF-1:0] metric_t;

    function automatic int num_states(input int k);
        return 1 << (k - 1);
    endfunction

    // Encoder register is {state, u} with u in the LSB; returns {c1, c0}.
    function automatic logic [1:0] codeword(input int unsigned st, input logic u,
                                            input int unsigned g0, input int unsigned g1);
        logic [31:0] r;
        r = {st[30:0], u};
        return {^(r & g1), ^(r & g0)};
    endfunction

    function automatic logic [BM_W_MAX-1:0] bm_slice(input logic [BUS_W-1:0] bus,
                                                     input logic [1:0] c,
                                                     input int unsigned w);
        logic [BUS_W-1:0] mask;
        mask = (BUS_W'(1) << w) - BUS_W'(1);
        return BM_W_MAX'((bus >> (32'(c) * w)) & mask);
    endfunction

endpackage

// File: rtl/viterbi_acs_butterfly.sv
// One trellis butterfly: new states 2*IDX and 2*IDX+1 fed by predecessors
// IDX and IDX + 2^(K-2). Purely combinational; the top owns the metric registers.
module viterbi_acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int           K        = 3,
    parameter int           IDX      = 0,
    parameter logic [K-1:0] G0       = 3'o7,
    parameter logic [K-1:0] G1       = 3'o5,
    parameter int           METRIC_W = 14,
    parameter int           BM_W     = 6
) (
    input  logic [METRIC_W-1:0]   i_pm_p0,
    input  logic [METRIC_W-1:0]   i_pm_p1,
    input  logic [METRIC_W-1:0]   i_sub,
    input  logic [4*BM_W-1:0]     i_bm,
    output logic [2*METRIC_W-1:0] o_pm,
    output logic [1:0]            o_dec,
    output logic                  o_ovf
);

    localparam int HALF  = 1 << (K - 2);
    localparam int P1    = IDX + HALF;
    localparam int SUM_W = METRIC_W + 1;

    logic [METRIC_W-1:0] w_b0, w_b1;
    logic [BUS_W-1:0]    w_bus;
    logic [1:0]          w_ovf;

    assign w_b0  = i_pm_p0 - i_sub;
    assign w_b1  = i_pm_p1 - i_sub;
    assign w_bus = BUS_W'(i_bm);
    assign o_ovf = |w_ovf;

    for (genvar u = 0; u < 2; u++) begin : g_u
        localparam logic [1:0] C0 = codeword(32'(IDX), 1'(u), 32'(G0), 32'(G1));
        localparam logic [1:0] C1 = codeword(32'(P1),  1'(u), 32'(G0), 32'(G1));

        logic [SUM_W-1:0] w_cand0, w_cand1;
        logic             w_sel;

        assign w_cand0 = {1'b0, w_b0} + SUM_W'(bm_slice(w_bus, C0, BM_W));
        assign w_cand1 = {1'b0, w_b1} + SUM_W'(bm_slice(w_bus, C1, BM_W));
        // strict compare: ties keep the upper-branch predecessor
        assign w_sel   = (w_cand1 < w_cand0);

        assign o_dec[u] = w_sel;
        assign o_pm[u*METRIC_W +: METRIC_W] = w_sel ? w_cand1[METRIC_W-1:0] : w_cand0[METRIC_W-1:0];
        assign w_ovf[u] = w_sel ? w_cand1[METRIC_W] : w_cand0[METRIC_W];
    end

endmodule

// File: rtl/viterbi_acs_array.sv
// Full-parallel add-compare-select over all 2^(K-1) states, one symbol per
// cycle, with threshold normalisation and a registered best-state stage.
module viterbi_acs_array
    import viterbi_pkg::*;
#(
    parameter int           K           = 3,
    parameter logic [K-1:0] G0          = 3'o7,
    parameter logic [K-1:0] G1          = 3'o5,
    parameter int           METRIC_W    = 14,
    parameter int           BM_W        = 6,
    parameter int           NORM_THRESH = 4096,
    parameter int           INIT_BIAS   = 512,
    localparam int          NUM_STATES  = num_states(K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  start_uniform,
    input  logic                  in_valid,
    input  logic [4*BM_W-1:0]     bm,
    output logic                  dec_valid,
    output logic [NUM_STATES-1:0] dec_bits,
    output logic                  norm_event,
    output logic                  best_valid,
    output logic [K-2:0]          best_state,
    output logic [METRIC_W-1:0]   best_metric,
    output logic [15:0]           sym_cnt
);

    localparam int                  HALF = NUM_STATES / 2;
    localparam logic [METRIC_W-1:0] THR  = METRIC_W'(NORM_THRESH);
    localparam logic [METRIC_W-1:0] BIAS = METRIC_W'(INIT_BIAS);

    logic [NUM_STATES-1:0][METRIC_W-1:0] r_pm, w_pm_cur, w_pm_nxt;
    logic [NUM_STATES-1:0]               r_dec, w_dec;
    logic [HALF-1:0]                     w_ovf;
    logic [1:0]                          r_vld_pipe;
    logic                                r_norm, w_norm, w_any_start;
    logic [METRIC_W-1:0]                 w_min, w_sub, r_best_metric;
    logic [K-2:0]                        w_min_idx, r_best_state;
    logic [15:0]                         r_cnt;

    assign w_any_start = start | start_uniform;

    // A start in the same cycle as a symbol feeds the initialised metrics straight in.
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            w_pm_cur[s] = r_pm[s];
            if (start_uniform)
                w_pm_cur[s] = '0;
            else if (start)
                w_pm_cur[s] = (s == 0) ? '0 : BIAS;
        end
    end

    always_comb begin
        w_min     = r_pm[0];
        w_min_idx = '0;
        for (int s = 1; s < NUM_STATES; s++) begin
            if (r_pm[s] < w_min) begin
                w_min     = r_pm[s];
                w_min_idx = (K-1)'(s);
            end
        end
    end

    // Initialised metrics always have a zero minimum, so a start never normalises.
    assign w_norm = !w_any_start && (w_min >= THR);
    assign w_sub  = w_norm ? THR : '0;

    for (genvar i = 0; i < HALF; i++) begin : g_bfly
        viterbi_acs_butterfly #(
            .K(K), .IDX(i), .G0(G0), .G1(G1), .METRIC_W(METRIC_W), .BM_W(BM_W)
        ) u_bfly (
            .i_pm_p0 (w_pm_cur[i]),
            .i_pm_p1 (w_pm_cur[i+HALF]),
            .i_sub   (w_sub),
            .i_bm    (bm),
            .o_pm    (w_pm_nxt[2*i+1 -: 2]),
            .o_dec   (w_dec[2*i+1 -: 2]),
            .o_ovf   (w_ovf[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pm          <= '0;
            r_dec         <= '0;
            r_vld_pipe    <= '0;
            r_norm        <= 1'b0;
            r_cnt         <= '0;
            r_best_state  <= '0;
            r_best_metric <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], in_valid};
            r_norm     <= in_valid & w_norm;
            if (in_valid) begin
                r_pm  <= w_pm_nxt;
                r_dec <= w_dec;
            end else if (w_any_start) begin
                r_pm  <= w_pm_cur;
            end
            if (w_any_start)
                r_cnt <= in_valid ? 16'd1 : 16'd0;
            else if (in_valid && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
            // r_pm already holds the updated metrics while dec_valid is high
            if (r_vld_pipe[0]) begin
                r_best_state  <= w_min_idx;
                r_best_metric <= w_min;
            end
        end
    end

    assign dec_valid   = r_vld_pipe[0];
    assign best_valid  = r_vld_pipe[1];
    assign dec_bits    = r_dec;
    assign norm_event  = r_norm;
    assign best_state  = r_best_state;
    assign best_metric = r_best_metric;
    assign sym_cnt     = r_cnt;

    a_no_ovf: assert property (@(posedge clk) disable iff (!rst) in_valid |-> !(|w_ovf));

endmodule
